// File: rtl/s2p_pkg.sv
// Shared definitions for the serial display/peripheral link (P2S transmitter
// and S2P receiver): receiver state encoding, counter width helper and the
// idle levels of the four link lines.
package s2p_pkg;

    // Receiver frame state: IDLE means no bits held, SHIFT means a partial frame.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Idle (undriven / between-frame) levels of the link lines.
    localparam logic SCLK_IDLE  = 1'b1;
    localparam logic SCLRN_IDLE = 1'b1;
    localparam logic PEN_IDLE   = 1'b1;
    localparam logic SIN_IDLE   = 1'b0;

    // Width of a counter able to hold 0..bit_width inclusive.
    function automatic int unsigned cnt_width(input int unsigned bit_width);
        return $clog2(bit_width + 1);
    endfunction

endpackage

// File: rtl/s2p_rx_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous link input.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   din       - asynchronous input pin
//   level     - synchronized level, time-aligned with rise/fall
//   rise      - one-cycle pulse on a synchronized 0->1 transition
//   fall      - one-cycle pulse on a synchronized 1->0 transition
// All outputs are registered. Reset loads RST_VAL everywhere so a line
// sitting at its idle level produces no edge when reset releases.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   synced;

    assign synced = chain[SYNC_STAGES-1];

    // Flop chain, one-cycle history copy and registered edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            level <= synced;
            rise  <= synced & ~level;
            fall  <= ~synced & level;
        end
    end

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver for the P2S link.
// Oversamples sclk/sclrn/sin/pen with clk, shifts sin in MSB-first on each
// sclk rising edge and commits the frame on each pen rising edge.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   sclk       - serial clock (asynchronous)
//   sclrn      - active-low frame clear
//   sin        - serial data, valid at sclk rising edge
//   pen        - latch enable, rising edge commits
//   par_out    - last good frame, bit BIT_WIDTH-1 received first
//   valid      - one-cycle pulse when par_out updates
//   frame_err  - one-cycle pulse on a short, empty or overrun frame
//   busy       - high while a frame is partially received
//   bit_cnt    - bits received in the current frame (saturates at BIT_WIDTH)
module s2p_rx
    import s2p_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sclk,
    input  logic                                 sclrn,
    input  logic                                 sin,
    input  logic                                 pen,
    output logic [BIT_WIDTH-1:0]                 par_out,
    output logic                                 valid,
    output logic                                 frame_err,
    output logic                                 busy,
    output logic [cnt_width(BIT_WIDTH)-1:0]      bit_cnt
);

    localparam int unsigned          CNT_W = cnt_width(BIT_WIDTH);
    localparam logic [CNT_W-1:0]     FULL  = CNT_W'(BIT_WIDTH);

    logic sclk_rise, pen_rise, sclrn_s, sin_s;
    logic sclk_level_unused, sclk_fall_unused;
    logic pen_level_unused, pen_fall_unused;
    logic sclrn_rise_unused, sclrn_fall_unused;
    logic sin_rise_unused, sin_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SCLRN_IDLE)) u_sync_sclrn (
        .clk   (clk),
        .rst   (rst),
        .din   (sclrn),
        .level (sclrn_s),
        .rise  (sclrn_rise_unused),
        .fall  (sclrn_fall_unused)
    );

    // sin shares sclk's synchronizer depth so its level lines up with sclk_rise.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SIN_IDLE)) u_sync_sin (
        .clk   (clk),
        .rst   (rst),
        .din   (sin),
        .level (sin_s),
        .rise  (sin_rise_unused),
        .fall  (sin_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(PEN_IDLE)) u_sync_pen (
        .clk   (clk),
        .rst   (rst),
        .din   (pen),
        .level (pen_level_unused),
        .rise  (pen_rise),
        .fall  (pen_fall_unused)
    );

    state_t                 state, state_next;
    logic [BIT_WIDTH-1:0]   shift_reg, shift_next;
    logic [BIT_WIDTH-1:0]   par_next;
    logic [CNT_W-1:0]       cnt_next;
    logic                   overrun, overrun_next;
    logic                   valid_next, err_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath: clear > commit > shift. A commit in the same
    // cycle as an sclk edge swallows that edge.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        cnt_next     = bit_cnt;
        overrun_next = overrun;
        par_next     = par_out;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        if (!sclrn_s) begin
            shift_next   = '0;
            cnt_next     = '0;
            overrun_next = 1'b0;
            state_next   = IDLE;
        end else if (pen_rise) begin
            if (bit_cnt == FULL && !overrun) begin
                par_next   = shift_reg;
                valid_next = 1'b1;
            end else begin
                err_next   = 1'b1;
            end
            cnt_next     = '0;
            overrun_next = 1'b0;
            state_next   = IDLE;
        end else if (sclk_rise) begin
            shift_next = {shift_reg[BIT_WIDTH-2:0], sin_s};
            state_next = SHIFT;
            if (bit_cnt < FULL) begin
                cnt_next = bit_cnt + CNT_W'(1);
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            overrun   <= 1'b0;
            par_out   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            bit_cnt   <= cnt_next;
            overrun   <= overrun_next;
            par_out   <= par_next;
            valid     <= valid_next;
            frame_err <= err_next;
            busy      <= (state_next == SHIFT);
        end
    end

endmodule

// File: tb/tb_s2p_rx.sv
// Directed self-checking bench for s2p_rx (BIT_WIDTH=64, SYNC_STAGES=2).
module tb_s2p_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, sclrn, sin, pen;
    logic [63:0] par_out;
    logic        valid, frame_err, busy;
    logic [6:0]  bit_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    s2p_rx #(.BIT_WIDTH(64), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .sclrn     (sclrn),
        .sin       (sin),
        .pen       (pen),
        .par_out   (par_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters.
    always @(posedge clk) begin
        if (valid)              valid_cnt++;
        if (frame_err)          err_cnt++;
        if (valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One sclk pulse: 4 clk low (sin changes here), 4 clk high.
    task automatic send_bit(input logic b);
        @(negedge clk);
        sclk = 1'b0;
        sin  = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends n bits of w MSB-first; bits beyond 64 are zero.
    task automatic send_word(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(i < 64 ? w[63 - i] : 1'b0);
        end
    endtask

    // pen low then high; checks exact pulse timing (3 clk after first sample).
    task automatic commit(input string tag, input logic exp_valid);
        @(negedge clk);
        pen = 1'b0;
        repeat (4) @(negedge clk);
        pen = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_early"}, {62'd0, valid, frame_err}, 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(valid), 64'(exp_valid));
        check({tag, "_err"}, 64'(frame_err), 64'(!exp_valid));
        @(negedge clk);
        check({tag, "_pulse_end"}, {62'd0, valid, frame_err}, 64'd0);
        check({tag, "_cnt0"}, 64'(bit_cnt), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int v0, e0;
        logic [63:0] words [3];
        words[0] = 64'h0123_4567_89AB_CDEF;
        words[1] = 64'h8000_0000_0000_0001;
        words[2] = 64'h5A5A_C3C3_0F0F_9669;

        rst = 1'b1; sclk = 1'b1; sclrn = 1'b1; sin = 1'b0; pen = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_par", par_out, 64'd0);
        check("rst_flags", {59'd0, valid, frame_err, busy, 2'b00}, 64'd0);
        check("rst_cnt", 64'(bit_cnt), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_quiet", 64'(valid_cnt + err_cnt), 64'd0);

        // 1: good frame
        send_word(64'hDEAD_BEEF_0123_4567, 64);
        check("t1_cnt64", 64'(bit_cnt), 64'd64);
        check("t1_busy", 64'(busy), 64'd1);
        commit("t1", 1'b1);
        check("t1_par", par_out, 64'hDEAD_BEEF_0123_4567);

        // 2: short frame
        send_word(64'h1111_2222_3333_4444, 63);
        check("t2_cnt63", 64'(bit_cnt), 64'd63);
        commit("t2", 1'b0);
        check("t2_par_hold", par_out, 64'hDEAD_BEEF_0123_4567);

        // 3: overrun
        send_word(64'hCAFE_F00D_CAFE_F00D, 65);
        check("t3_cnt_sat", 64'(bit_cnt), 64'd64);
        commit("t3", 1'b0);
        check("t3_par_hold", par_out, 64'hDEAD_BEEF_0123_4567);

        // 4: mid-frame clear then good frame
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 30);
        check("t4_cnt30", 64'(bit_cnt), 64'd30);
        @(negedge clk); sclrn = 1'b0;
        repeat (4) @(negedge clk); sclrn = 1'b1;
        check("t4_cleared_cnt", 64'(bit_cnt), 64'd0);
        check("t4_cleared_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        v0 = valid_cnt; e0 = err_cnt;
        send_word(64'hFFFF_0000_AAAA_5555, 64);
        commit("t4", 1'b1);
        check("t4_par", par_out, 64'hFFFF_0000_AAAA_5555);
        check("t4_one_valid", 64'(valid_cnt - v0), 64'd1);
        check("t4_no_err", 64'(err_cnt - e0), 64'd0);

        // 5a: pen and sclk rising on the same clk edge after 64 bits
        send_word(64'h0BAD_F00D_1234_ABCD, 64);
        @(negedge clk);
        sclk = 1'b0; pen = 1'b0; sin = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b1; pen = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_coll_valid", 64'(valid), 64'd1);
        check("t5_coll_par", par_out, 64'h0BAD_F00D_1234_ABCD);
        @(negedge clk);
        check("t5_coll_cnt0", 64'(bit_cnt), 64'd0);
        check("t5_coll_idle", 64'(busy), 64'd0);

        // 5b: rst mid-frame
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 10);
        check("t5_cnt10", 64'(bit_cnt), 64'd10);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rst_par", par_out, 64'd0);
        check("t5_rst_flags", {61'd0, valid, frame_err, busy}, 64'd0);
        check("t5_rst_cnt", 64'(bit_cnt), 64'd0);
        v0 = valid_cnt; e0 = err_cnt;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_rst_no_pulse", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);

        // 6a: pen held high across 3 frames
        v0 = valid_cnt; e0 = err_cnt;
        for (int f = 0; f < 3; f++) send_word(words[f], 64);
        repeat (6) @(negedge clk);
        check("t6_held_no_commit", 64'((valid_cnt - v0) + (err_cnt - e0)), 64'd0);
        check("t6_held_par", par_out, 64'd0);
        @(negedge clk); sclrn = 1'b0;
        repeat (4) @(negedge clk); sclrn = 1'b1;
        repeat (4) @(negedge clk);

        // 6b: back-to-back frames with pen toggling
        v0 = valid_cnt;
        for (int f = 0; f < 3; f++) begin
            send_word(words[f], 64);
            commit($sformatf("t6_f%0d", f), 1'b1);
            check($sformatf("t6_par%0d", f), par_out, words[f]);
        end
        check("t6_three_valid", 64'(valid_cnt - v0), 64'd3);
        check("never_both", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
